// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: parametrised GPIO pin core.
// Pad inputs pass a synchroniser and an optional per-pin debounce filter. The
// output data and output-enable registers take masked writes. Each pin can be
// switched to open-drain drive. Sticky interrupt state is fed by edge and level
// sources, and is cleared by write-one-to-clear.
//
// Strobe semantics: out_wr_i and oe_wr_i are single-cycle write strobes with no
// back-pressure. A strobe that is high at a rising clk_i edge commits its masked
// write at that edge. intr_clr_i and intr_test_i are also sampled every cycle.
// A set from any source (including intr_test_i) wins over intr_clr_i when both
// hit the same bit in the same cycle.
module gpio_pin_ctrl #(
  parameter int unsigned NumPins    = 32,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned CntW       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // pad side
  input  logic [NumPins-1:0] gpio_i,
  output logic [NumPins-1:0] gpio_o,
  output logic [NumPins-1:0] gpio_en_o,
  // output data / output enable writes
  input  logic               out_wr_i,
  input  logic [NumPins-1:0] out_mask_i,
  input  logic [NumPins-1:0] out_data_i,
  input  logic               oe_wr_i,
  input  logic [NumPins-1:0] oe_mask_i,
  input  logic [NumPins-1:0] oe_data_i,
  input  logic [NumPins-1:0] od_en_i,
  // input filtering
  input  logic [NumPins-1:0] filt_en_i,
  input  logic [CntW-1:0]    filt_thresh_i,
  // readback
  output logic [NumPins-1:0] data_in_o,
  output logic [NumPins-1:0] out_q_o,
  output logic [NumPins-1:0] oe_q_o,
  // interrupts
  input  logic [NumPins-1:0] ie_rise_i,
  input  logic [NumPins-1:0] ie_fall_i,
  input  logic [NumPins-1:0] ie_hi_i,
  input  logic [NumPins-1:0] ie_lo_i,
  input  logic [NumPins-1:0] intr_en_i,
  input  logic [NumPins-1:0] intr_clr_i,
  input  logic [NumPins-1:0] intr_test_i,
  output logic [NumPins-1:0] intr_state_o,
  output logic [NumPins-1:0] intr_o
);

  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [NumPins-1:0] sync_q [SyncStages];
  logic [NumPins-1:0] sync_d [SyncStages];
  logic [NumPins-1:0] sync_val;

  // Shift the raw pad value one stage down the synchroniser chain each cycle.
  always_comb begin
    sync_d[0] = gpio_i;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign sync_val = sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Debounce filter
  // cand tracks the last synchronised value seen. cnt counts the cycles that
  // cand has matched the input, saturating at the threshold. stable takes the
  // value of cand once the count has reached the threshold. The filter runs
  // whether or not the pin has filtering enabled. Switching filt_en therefore
  // only changes which value drives data_in, and this takes effect at once.
  // ---------------------------------------------------------------------------
  logic [NumPins-1:0] cand_q, cand_d;
  logic [NumPins-1:0] stable_q, stable_d;
  logic [CntW-1:0]    cnt_q [NumPins];
  logic [CntW-1:0]    cnt_d [NumPins];

  // Per-pin candidate/counter/stable update.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    for (int p = 0; p < NumPins; p++) begin
      cnt_d[p] = cnt_q[p];
      if (sync_val[p] != cand_q[p]) begin
        cand_d[p] = sync_val[p];
        cnt_d[p]  = '0;
      end else if (cnt_q[p] < filt_thresh_i) begin
        cnt_d[p] = cnt_q[p] + CntOne;
      end else begin
        stable_d[p] = cand_q[p];
      end
    end
  end

  // Filter state flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q   <= '0;
      stable_q <= '0;
      for (int p = 0; p < NumPins; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      for (int p = 0; p < NumPins; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  logic [NumPins-1:0] data_in;

  assign data_in   = (filt_en_i & stable_q) | (~filt_en_i & sync_val);
  assign data_in_o = data_in;

  // ---------------------------------------------------------------------------
  // Output data and output-enable registers
  // ---------------------------------------------------------------------------
  logic [NumPins-1:0] out_q, out_d;
  logic [NumPins-1:0] oe_q, oe_d;

  // Masked writes. The two strobes are independent and may fire together.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (out_wr_i) begin
      out_d = (out_mask_i & out_data_i) | (~out_mask_i & out_q);
    end
    if (oe_wr_i) begin
      oe_d = (oe_mask_i & oe_data_i) | (~oe_mask_i & oe_q);
    end
  end

  // Output and OE register flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign out_q_o = out_q;
  assign oe_q_o  = oe_q;

  // Pad drive. An open-drain pin never drives high. It enables the pad only
  // while its output register holds a 0.
  assign gpio_o    = ~od_en_i & out_q;
  assign gpio_en_o = oe_q & ~(od_en_i & out_q);

  // ---------------------------------------------------------------------------
  // Interrupts
  // prev resets to 0. A pin that is already high when reset is released, with
  // its rising source enabled, therefore raises one rising event.
  // ---------------------------------------------------------------------------
  logic [NumPins-1:0] prev_q, prev_d;
  logic [NumPins-1:0] intr_state_q, intr_state_d;
  logic [NumPins-1:0] ev_rise, ev_fall, ev_hi, ev_lo, ev_any;

  // Event detection and sticky state update; set wins over clear.
  always_comb begin
    ev_rise      = ~prev_q & data_in & ie_rise_i;
    ev_fall      = prev_q & ~data_in & ie_fall_i;
    ev_hi        = data_in & ie_hi_i;
    ev_lo        = ~data_in & ie_lo_i;
    ev_any       = ev_rise | ev_fall | ev_hi | ev_lo | intr_test_i;
    prev_d       = data_in;
    intr_state_d = (intr_state_q & ~intr_clr_i) | ev_any;
  end

  // Interrupt state and previous-input flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q       <= '0;
      intr_state_q <= '0;
    end else begin
      prev_q       <= prev_d;
      intr_state_q <= intr_state_d;
    end
  end

  assign intr_state_o = intr_state_q;
  assign intr_o       = intr_state_q & intr_en_i;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Testbench for gpio_pin_ctrl: directed scenarios plus randomized traffic,
// checked against a behavioural model held in this file.
module tb_gpio_pin_ctrl;

  localparam int NP = 32;
  localparam int SS = 2;
  localparam int CW = 8;
  localparam int HistLen = 64;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NP-1:0] gpio_i, gpio_o, gpio_en_o;
  logic          out_wr_i, oe_wr_i;
  logic [NP-1:0] out_mask_i, out_data_i, oe_mask_i, oe_data_i, od_en_i;
  logic [NP-1:0] filt_en_i;
  logic [CW-1:0] filt_thresh_i;
  logic [NP-1:0] data_in_o, out_q_o, oe_q_o;
  logic [NP-1:0] ie_rise_i, ie_fall_i, ie_hi_i, ie_lo_i;
  logic [NP-1:0] intr_en_i, intr_clr_i, intr_test_i, intr_state_o, intr_o;

  gpio_pin_ctrl #(.NumPins(NP), .SyncStages(SS), .CntW(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_en_o(gpio_en_o),
    .out_wr_i(out_wr_i), .out_mask_i(out_mask_i), .out_data_i(out_data_i),
    .oe_wr_i(oe_wr_i), .oe_mask_i(oe_mask_i), .oe_data_i(oe_data_i),
    .od_en_i(od_en_i), .filt_en_i(filt_en_i), .filt_thresh_i(filt_thresh_i),
    .data_in_o(data_in_o), .out_q_o(out_q_o), .oe_q_o(oe_q_o),
    .ie_rise_i(ie_rise_i), .ie_fall_i(ie_fall_i), .ie_hi_i(ie_hi_i), .ie_lo_i(ie_lo_i),
    .intr_en_i(intr_en_i), .intr_clr_i(intr_clr_i), .intr_test_i(intr_test_i),
    .intr_state_o(intr_state_o), .intr_o(intr_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // gq holds raw pad samples, newest first. sq holds the synchronised value
  // seen after each edge, newest first. The filtered value adopts a level once
  // the last thresh+2 synchronised samples all agree on it.
  logic [NP-1:0] m_out, m_oe, m_stable, m_prev, m_istate;
  logic [NP-1:0] gq[$];
  logic [NP-1:0] sq[$];

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_stable = '0; m_prev = '0; m_istate = '0;
    gq.delete(); sq.delete();
    repeat (HistLen) begin
      gq.push_back('0);
      sq.push_back('0);
    end
  endtask

  function automatic logic [NP-1:0] m_sync();
    return gq[SS-1];
  endfunction

  function automatic logic [NP-1:0] m_data_in();
    logic [NP-1:0] s, r;
    s = m_sync();
    for (int p = 0; p < NP; p++) r[p] = filt_en_i[p] ? m_stable[p] : s[p];
    return r;
  endfunction

  function automatic logic [NP-1:0] m_gpio_o();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = od_en_i[p] ? 1'b0 : m_out[p];
    return r;
  endfunction

  function automatic logic [NP-1:0] m_gpio_en();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = od_en_i[p] ? (m_oe[p] && !m_out[p]) : m_oe[p];
    return r;
  endfunction

  function automatic logic [NP-1:0] m_intr();
    return m_istate & intr_en_i;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_update();
    logic [NP-1:0] din, ev, s0, sk, nsync;
    logic same;
    din = m_data_in();
    ev = '0;
    for (int p = 0; p < NP; p++) begin
      if (ie_rise_i[p] && !m_prev[p] && din[p]) ev[p] = 1'b1;
      if (ie_fall_i[p] && m_prev[p] && !din[p]) ev[p] = 1'b1;
      if (ie_hi_i[p] && din[p]) ev[p] = 1'b1;
      if (ie_lo_i[p] && !din[p]) ev[p] = 1'b1;
      if (intr_test_i[p]) ev[p] = 1'b1;
    end
    m_istate = (m_istate & ~intr_clr_i) | ev;
    m_prev = din;
    if (out_wr_i) m_out = (out_mask_i & out_data_i) | (~out_mask_i & m_out);
    if (oe_wr_i) m_oe = (oe_mask_i & oe_data_i) | (~oe_mask_i & m_oe);
    s0 = sq[0];
    for (int p = 0; p < NP; p++) begin
      same = 1'b1;
      for (int k = 1; k <= int'(filt_thresh_i) + 1; k++) begin
        sk = sq[k];
        if (sk[p] !== s0[p]) same = 1'b0;
      end
      if (same) m_stable[p] = s0[p];
    end
    gq.push_front(gpio_i);
    void'(gq.pop_back());
    nsync = gq[SS-1];
    sq.push_front(nsync);
    void'(sq.pop_back());
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    gpio_i = '0; out_wr_i = 1'b0; oe_wr_i = 1'b0;
    out_mask_i = '0; out_data_i = '0; oe_mask_i = '0; oe_data_i = '0;
    od_en_i = '0; filt_en_i = '0; filt_thresh_i = '0;
    ie_rise_i = '0; ie_fall_i = '0; ie_hi_i = '0; ie_lo_i = '0;
    intr_en_i = '0; intr_clr_i = '0; intr_test_i = '0;
  endtask

  // One clock: model follows the rising edge, control returns at the falling edge.
  task automatic step();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (gpio_o !== '0) begin n_fail++; $display("FAIL reset_gpio_o got=%h exp=0", gpio_o); end
    n_checks++; if (gpio_en_o !== '0) begin n_fail++; $display("FAIL reset_gpio_en got=%h exp=0", gpio_en_o); end
    n_checks++; if (data_in_o !== '0) begin n_fail++; $display("FAIL reset_data_in got=%h exp=0", data_in_o); end
    n_checks++; if (out_q_o !== '0) begin n_fail++; $display("FAIL reset_out_q got=%h exp=0", out_q_o); end
    n_checks++; if (oe_q_o !== '0) begin n_fail++; $display("FAIL reset_oe_q got=%h exp=0", oe_q_o); end
    n_checks++; if (intr_state_o !== '0) begin n_fail++; $display("FAIL reset_intr_state got=%h exp=0", intr_state_o); end
    n_checks++; if (intr_o !== '0) begin n_fail++; $display("FAIL reset_intr_o got=%h exp=0", intr_o); end
    out_wr_i = 1'b1; out_mask_i = 32'h0000FFFF; out_data_i = 32'hFFFFFFFF;
    step();
    out_wr_i = 1'b0;
    n_checks++; if (out_q_o !== 32'h0000FFFF) begin n_fail++; $display("FAIL masked_write got=%h exp=0000ffff", out_q_o); end
    n_checks++; if (out_q_o !== m_out) begin n_fail++; $display("FAIL masked_write_model got=%h exp=%h", out_q_o, m_out); end
  endtask

  task automatic test_pad_drive();
    do_reset();
    out_wr_i = 1'b1; out_mask_i = '1; out_data_i = 32'hA5;
    oe_wr_i = 1'b1; oe_mask_i = '1; oe_data_i = 32'hFF;
    step();
    out_wr_i = 1'b0; oe_wr_i = 1'b0;
    n_checks++; if (gpio_o !== 32'hA5) begin n_fail++; $display("FAIL pushpull_gpio_o got=%h exp=a5", gpio_o); end
    n_checks++; if (gpio_en_o !== 32'hFF) begin n_fail++; $display("FAIL pushpull_gpio_en got=%h exp=ff", gpio_en_o); end
    od_en_i = 32'h0F;
    #1;
    n_checks++; if (gpio_o !== 32'hA0) begin n_fail++; $display("FAIL od_gpio_o got=%h exp=a0", gpio_o); end
    n_checks++; if (gpio_en_o !== 32'hFA) begin n_fail++; $display("FAIL od_gpio_en got=%h exp=fa", gpio_en_o); end
    n_checks++; if (gpio_en_o !== m_gpio_en()) begin n_fail++; $display("FAIL od_gpio_en_model got=%h exp=%h", gpio_en_o, m_gpio_en()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_wr_i = 1'b1; out_mask_i = 32'hFF; out_data_i = 32'h12;
    oe_wr_i = 1'b1; oe_mask_i = 32'hF0; oe_data_i = 32'hFF;
    step();
    n_checks++; if (out_q_o !== 32'h12) begin n_fail++; $display("FAIL b2b_out_1 got=%h exp=12", out_q_o); end
    n_checks++; if (oe_q_o !== 32'hF0) begin n_fail++; $display("FAIL b2b_oe_1 got=%h exp=f0", oe_q_o); end
    out_mask_i = 32'h0F; out_data_i = 32'h0F;
    oe_mask_i = 32'h0F; oe_data_i = 32'h05;
    step();
    out_wr_i = 1'b0; oe_wr_i = 1'b0;
    n_checks++; if (out_q_o !== 32'h1F) begin n_fail++; $display("FAIL b2b_out_2 got=%h exp=1f", out_q_o); end
    n_checks++; if (oe_q_o !== 32'hF5) begin n_fail++; $display("FAIL b2b_oe_2 got=%h exp=f5", oe_q_o); end
  endtask

  task automatic test_debounce();
    do_reset();
    filt_en_i = 32'h1; filt_thresh_i = 8'd4;
    repeat (10) step();
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++; if (data_in_o[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_k%0d got=%b exp=0", k, data_in_o[0]); end
    end
    gpio_i[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++; if (data_in_o[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_after_k%0d got=%b exp=0", k, data_in_o[0]); end
    end
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (data_in_o[0] !== ((k >= SS + 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL debounce_rise_k%0d got=%b exp=%b", k, data_in_o[0], (k >= SS + 6));
      end
    end
    gpio_i[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++; if (data_in_o !== m_data_in()) begin n_fail++; $display("FAIL debounce_fall_k%0d got=%h exp=%h", k, data_in_o, m_data_in()); end
    end
  endtask

  task automatic test_rise_intr();
    int lat;
    do_reset();
    ie_rise_i = 32'h8; intr_en_i = 32'h8;
    repeat (4) step();
    gpio_i[3] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      step();
      if (intr_state_o[3] === 1'b1) lat = k;
    end
    n_checks++; if (lat != SS + 1) begin n_fail++; $display("FAIL rise_latency got=%0d exp=%0d", lat, SS + 1); end
    n_checks++; if (intr_o !== 32'h8) begin n_fail++; $display("FAIL rise_intr_o got=%h exp=8", intr_o); end
    gpio_i[3] = 1'b0;
    repeat (6) step();
    n_checks++; if (intr_state_o !== 32'h8) begin n_fail++; $display("FAIL rise_sticky got=%h exp=8", intr_state_o); end
    n_checks++; if (intr_o !== m_intr()) begin n_fail++; $display("FAIL rise_sticky_model got=%h exp=%h", intr_o, m_intr()); end
    intr_clr_i = 32'h8;
    step();
    intr_clr_i = '0;
    n_checks++; if (intr_state_o !== 32'h0) begin n_fail++; $display("FAIL rise_clear got=%h exp=0", intr_state_o); end
  endtask

  task automatic test_level_intr();
    do_reset();
    ie_hi_i = 32'h20; intr_en_i = 32'h20;
    gpio_i[5] = 1'b1;
    repeat (5) step();
    n_checks++; if (intr_state_o[5] !== 1'b1) begin n_fail++; $display("FAIL level_set got=%b exp=1", intr_state_o[5]); end
    intr_clr_i = 32'h20;
    step();
    intr_clr_i = '0;
    n_checks++; if (intr_state_o[5] !== 1'b1) begin n_fail++; $display("FAIL level_set_beats_clr got=%b exp=1", intr_state_o[5]); end
    intr_test_i = 32'h80;
    step();
    intr_test_i = '0;
    n_checks++; if (intr_state_o[7] !== 1'b1) begin n_fail++; $display("FAIL test_state got=%b exp=1", intr_state_o[7]); end
    n_checks++; if (intr_o[7] !== 1'b0) begin n_fail++; $display("FAIL test_masked got=%b exp=0", intr_o[7]); end
    n_checks++; if (intr_o !== m_intr()) begin n_fail++; $display("FAIL level_intr_model got=%h exp=%h", intr_o, m_intr()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    filt_en_i = '1; filt_thresh_i = 8'd4; ie_rise_i = '1;
    intr_test_i = 32'hFF;
    step();
    intr_test_i = '0;
    n_checks++; if (intr_state_o !== 32'hFF) begin n_fail++; $display("FAIL mid_pre_state got=%h exp=ff", intr_state_o); end
    gpio_i = 32'hFFFF;
    out_wr_i = 1'b1; out_mask_i = '1; out_data_i = 32'h1234;
    oe_wr_i = 1'b1; oe_mask_i = '1; oe_data_i = 32'hFFFF;
    repeat (4) step();
    out_wr_i = 1'b0; oe_wr_i = 1'b0;
    rst_ni = 1'b0;
    gpio_i = '0;
    #1;
    n_checks++; if (intr_state_o !== '0) begin n_fail++; $display("FAIL mid_rst_state got=%h exp=0", intr_state_o); end
    n_checks++; if (out_q_o !== '0 || oe_q_o !== '0) begin n_fail++; $display("FAIL mid_rst_regs got=%h/%h exp=0/0", out_q_o, oe_q_o); end
    n_checks++; if (gpio_o !== '0 || gpio_en_o !== '0) begin n_fail++; $display("FAIL mid_rst_pad got=%h/%h exp=0/0", gpio_o, gpio_en_o); end
    n_checks++; if (data_in_o !== '0 || intr_o !== '0) begin n_fail++; $display("FAIL mid_rst_in got=%h/%h exp=0/0", data_in_o, intr_o); end
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++; if (intr_state_o !== '0) begin n_fail++; $display("FAIL mid_post_k%0d got=%h exp=0", k, intr_state_o); end
      n_checks++; if (data_in_o !== m_data_in()) begin n_fail++; $display("FAIL mid_post_din_k%0d got=%h exp=%h", k, data_in_o, m_data_in()); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      filt_thresh_i = CW'($urandom_range(0, 5));
      filt_en_i = $urandom;
      ie_rise_i = $urandom; ie_fall_i = $urandom;
      ie_hi_i = $urandom & $urandom & $urandom;
      ie_lo_i = $urandom & $urandom & $urandom;
      intr_en_i = $urandom;
      for (int c = 0; c < 400; c++) begin
        gpio_i ^= ($urandom & $urandom & $urandom);
        out_wr_i = ($urandom_range(0, 3) == 0);
        out_mask_i = $urandom; out_data_i = $urandom;
        oe_wr_i = ($urandom_range(0, 3) == 0);
        oe_mask_i = $urandom; oe_data_i = $urandom;
        if ($urandom_range(0, 15) == 0) od_en_i = $urandom;
        if ($urandom_range(0, 15) == 0) filt_en_i = $urandom;
        intr_clr_i = $urandom & $urandom & $urandom;
        intr_test_i = ($urandom_range(0, 7) == 0) ? ($urandom & $urandom & $urandom & $urandom) : '0;
        #1;
        n_checks++; if (gpio_o !== m_gpio_o()) begin n_fail++; $display("FAIL rnd_gpio_o r%0d c%0d got=%h exp=%h", r, c, gpio_o, m_gpio_o()); end
        n_checks++; if (gpio_en_o !== m_gpio_en()) begin n_fail++; $display("FAIL rnd_gpio_en r%0d c%0d got=%h exp=%h", r, c, gpio_en_o, m_gpio_en()); end
        n_checks++; if (data_in_o !== m_data_in()) begin n_fail++; $display("FAIL rnd_data_in r%0d c%0d got=%h exp=%h", r, c, data_in_o, m_data_in()); end
        n_checks++; if (out_q_o !== m_out) begin n_fail++; $display("FAIL rnd_out_q r%0d c%0d got=%h exp=%h", r, c, out_q_o, m_out); end
        n_checks++; if (oe_q_o !== m_oe) begin n_fail++; $display("FAIL rnd_oe_q r%0d c%0d got=%h exp=%h", r, c, oe_q_o, m_oe); end
        n_checks++; if (intr_state_o !== m_istate) begin n_fail++; $display("FAIL rnd_intr_state r%0d c%0d got=%h exp=%h", r, c, intr_state_o, m_istate); end
        n_checks++; if (intr_o !== m_intr()) begin n_fail++; $display("FAIL rnd_intr_o r%0d c%0d got=%h exp=%h", r, c, intr_o, m_intr()); end
        step();
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_pad_drive();
    test_back_to_back();
    test_debounce();
    test_rise_intr();
    test_level_intr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
